sram_slot_arbiter: RTL and testbench

SRAM_SLOT_ARBITER -- requirements
Module: sram_slot_arbiter

---
 rtl/sram_slot_arbiter.sv | 131 +++++++++++++
 tb/tb_sram_slot_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_slot_arbiter.sv
// Time-slotted arbiter sharing one asynchronous SRAM between a video fetch
// (slot 0), a CPU access (slots 4-5) and a host access window.
module sram_slot_arbiter #(
  parameter logic [4:0] VIDEO_BASE = 5'b00001,
  parameter int         HOST_FIRST = 7,
  parameter int         HOST_LAST  = 14
) (
  input  logic        clk25,
  input  logic        reset_n,
  input  logic [3:0]  slot,
  input  logic [12:0] vga_addr,
  output logic [15:0] vid_data,
  output logic        vid_valid,
  input  logic        cpu_rd,
  input  logic        cpu_wt,
  input  logic [15:0] cpu_adr,
  input  logic        cpu_byte,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_done,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [17:0] host_addr,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  output logic        host_ack,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_dq_o,
  output logic        ram_dq_oe,
  input  logic [15:0] ram_dq_i,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        ram_lb_n,
  output logic        ram_ub_n
);

  typedef enum logic [2:0] {IDLE, VID, CPU_A, CPU_B, HOST_A, HOST_B} state_t;

  state_t      state;
  logic        synced;     // set by the first video fetch after reset
  logic        acc_we;
  logic        acc_lb_n;
  logic        acc_ub_n;
  logic [15:0] acc_wdata;
  logic        in_host_window;

  assign in_host_window = (int'(slot) >= HOST_FIRST - 1) &&
                          (int'(slot) <= HOST_LAST - 2);

  // NOTE: all registered state uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      synced     <= 1'b0;
      ram_addr   <= '0;
      acc_we     <= 1'b0;
      acc_lb_n   <= 1'b0;
      acc_ub_n   <= 1'b0;
      acc_wdata  <= '0;
      vid_data   <= '0;
      vid_valid  <= 1'b0;
      cpu_rdata  <= '0;
      cpu_done   <= 1'b0;
      host_rdata <= '0;
      host_ack   <= 1'b0;
    end else begin
      vid_valid <= (state == VID);
      cpu_done  <= (state == CPU_B);
      host_ack  <= (state == HOST_B);
      if (state == VID)                cpu_rdata <= cpu_rdata;
      if (state == VID)                vid_data   <= ram_dq_i;
      if (state == CPU_B  && !acc_we)  cpu_rdata  <= ram_dq_i;
      if (state == HOST_B && !acc_we)  host_rdata <= ram_dq_i;

      // Video slot wins unconditionally; the other slots cannot collide with it.
      if (slot == 4'd15) begin
        state    <= VID;
        synced   <= 1'b1;
        ram_addr <= {VIDEO_BASE, vga_addr};
      end else if (synced && slot == 4'd3 && (cpu_rd || cpu_wt)) begin
        state     <= CPU_A;
        ram_addr  <= {3'b000, cpu_adr[15:1]};
        acc_we    <= cpu_wt;
        acc_lb_n  <= cpu_byte & cpu_adr[0];
        acc_ub_n  <= cpu_byte & ~cpu_adr[0];
        acc_wdata <= cpu_wdata;
      end else if (synced && state == IDLE && in_host_window && host_req) begin
        state     <= HOST_A;
        ram_addr  <= host_addr;
        acc_we    <= host_we;
        acc_lb_n  <= 1'b0;
        acc_ub_n  <= 1'b0;
        acc_wdata <= host_wdata;
      end else begin
        case (state)
          CPU_A:   state <= CPU_B;
          HOST_A:  state <= HOST_B;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign ram_dq_o = acc_wdata;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    ram_oe_n  = 1'b1;
    ram_we_n  = 1'b1;
    ram_dq_oe = 1'b0;
    ram_lb_n  = 1'b0;
    ram_ub_n  = 1'b0;
    case (state)
      VID: ram_oe_n = 1'b0;
      CPU_A, CPU_B, HOST_A, HOST_B: begin
        ram_lb_n = acc_lb_n;
        ram_ub_n = acc_ub_n;
        if (acc_we) begin
          // Write pulse in the first phase only; data held through the second.
          ram_dq_oe = 1'b1;
          ram_we_n  = !(state == CPU_A || state == HOST_A);
        end else begin
          ram_oe_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Self-checking bench: directed slot scenarios, then random traffic compared
// against a per-cycle access timeline model.
module tb_sram_slot_arbiter;

  localparam logic [4:0] VB = 5'b00001;
  localparam int         HF = 7;
  localparam int         HL = 14;

  logic        clk25 = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  slot = '0;
  logic [12:0] vga_addr = 13'h0123;
  logic [15:0] vid_data;
  logic        vid_valid;
  logic        cpu_rd = 1'b0, cpu_wt = 1'b0, cpu_byte = 1'b0;
  logic [15:0] cpu_adr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_done;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [17:0] host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic [15:0] host_rdata;
  logic        host_ack;
  logic [17:0] ram_addr;
  logic [15:0] ram_dq_o;
  logic        ram_dq_oe;
  logic [15:0] ram_dq_i = 16'hA5A5;
  logic        ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n;

  always #20 clk25 = ~clk25;

  sram_slot_arbiter #(.VIDEO_BASE(VB), .HOST_FIRST(HF), .HOST_LAST(HL)) dut (
    .clk25(clk25), .reset_n(reset_n), .slot(slot), .vga_addr(vga_addr),
    .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_rd(cpu_rd), .cpu_wt(cpu_wt), .cpu_adr(cpu_adr), .cpu_byte(cpu_byte),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .ram_addr(ram_addr), .ram_dq_o(ram_dq_o), .ram_dq_oe(ram_dq_oe),
    .ram_dq_i(ram_dq_i), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .ram_lb_n(ram_lb_n), .ram_ub_n(ram_ub_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t slot=%0d)", tag, got, exp, $time, slot);
    end
  endtask

  // Reference model: a short timeline of what the SRAM is doing each cycle.
  typedef enum int {K_NONE, K_VID, K_PH1, K_PH2} kind_e;
  typedef struct {
    kind_e       kind;
    bit          host;
    bit          we;
    bit          lb_n;
    bit          ub_n;
    logic [17:0] addr;
    logic [15:0] wdata;
  } access_t;

  access_t     plan[4];
  bit          frame_seen;
  logic [17:0] last_addr;
  logic [15:0] exp_vid_data, exp_cpu_rdata, exp_host_rdata;
  bit          exp_vid_valid, exp_cpu_done, exp_host_ack;
  bit          rand_en = 1'b0;
  bit          cpu_held = 1'b0, host_held = 1'b0;
  int          frame = 0;

  function automatic access_t no_access();
    access_t a;
    a.kind = K_NONE; a.host = 1'b0; a.we = 1'b0; a.lb_n = 1'b0; a.ub_n = 1'b0;
    a.addr = '0; a.wdata = '0;
    return a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) plan[i] = no_access();
    frame_seen = 1'b0;
    last_addr = '0;
    exp_vid_data = '0; exp_cpu_rdata = '0; exp_host_rdata = '0;
    exp_vid_valid = 1'b0; exp_cpu_done = 1'b0; exp_host_ack = 1'b0;
  endtask

  // Called at the rising edge with the inputs as they were during the ending cycle.
  task automatic model_edge();
    access_t ending;
    access_t a;
    ending = plan[0];
    exp_vid_valid = 1'b0; exp_cpu_done = 1'b0; exp_host_ack = 1'b0;
    if (ending.kind == K_VID) begin
      exp_vid_data  = ram_dq_i;
      exp_vid_valid = 1'b1;
    end
    if (ending.kind == K_PH2) begin
      if (ending.host) begin
        exp_host_ack = 1'b1;
        if (!ending.we) exp_host_rdata = ram_dq_i;
      end else begin
        exp_cpu_done = 1'b1;
        if (!ending.we) exp_cpu_rdata = ram_dq_i;
      end
    end
    for (int i = 0; i < 3; i++) plan[i] = plan[i+1];
    plan[3] = no_access();
    if (slot == 4'd15) begin
      a = no_access(); a.kind = K_VID; a.addr = {VB, vga_addr};
      plan[0] = a;
      frame_seen = 1'b1;
    end else if (frame_seen && slot == 4'd3 && (cpu_rd || cpu_wt)) begin
      a = no_access();
      a.kind  = K_PH1;
      a.we    = cpu_wt;
      a.lb_n  = cpu_byte && cpu_adr[0];
      a.ub_n  = cpu_byte && !cpu_adr[0];
      a.addr  = 18'(cpu_adr / 16'd2);
      a.wdata = cpu_wdata;
      plan[0] = a;
      a.kind  = K_PH2;
      plan[1] = a;
    end else if (frame_seen && ending.kind == K_NONE && host_req &&
                 int'(slot) >= HF - 1 && int'(slot) <= HL - 2) begin
      a = no_access();
      a.kind = K_PH1; a.host = 1'b1; a.we = host_we;
      a.addr = host_addr; a.wdata = host_wdata;
      plan[0] = a;
      a.kind  = K_PH2;
      plan[1] = a;
    end
    if (plan[0].kind != K_NONE) last_addr = plan[0].addr;
  endtask

  task automatic check_outputs();
    access_t c;
    logic e_oe_n, e_we_n, e_dq_oe, e_lb, e_ub;
    c = plan[0];
    e_oe_n = 1'b1; e_we_n = 1'b1; e_dq_oe = 1'b0; e_lb = 1'b0; e_ub = 1'b0;
    if (c.kind == K_VID) begin
      e_oe_n = 1'b0;
    end else if (c.kind != K_NONE) begin
      e_lb = c.lb_n; e_ub = c.ub_n;
      if (c.we) begin
        e_dq_oe = 1'b1;
        e_we_n  = (c.kind == K_PH2);
      end else begin
        e_oe_n = 1'b0;
      end
    end
    check("ram_addr", ram_addr, last_addr);
    check("oe_n", ram_oe_n, e_oe_n);
    check("we_n", ram_we_n, e_we_n);
    check("dq_oe", ram_dq_oe, e_dq_oe);
    check("lb_n", ram_lb_n, e_lb);
    check("ub_n", ram_ub_n, e_ub);
    if (e_dq_oe) check("dq_o", ram_dq_o, c.wdata);
    check("contention", ram_dq_oe & ~ram_oe_n, 0);
    check("vid_valid", vid_valid, exp_vid_valid);
    check("vid_data", vid_data, exp_vid_data);
    check("cpu_done", cpu_done, exp_cpu_done);
    check("cpu_rdata", cpu_rdata, exp_cpu_rdata);
    check("host_ack", host_ack, exp_host_ack);
    check("host_rdata", host_rdata, exp_host_rdata);
  endtask

  task automatic drive_random();
    int r;
    ram_dq_i = 16'($urandom);
    vga_addr = 13'($urandom);
    if (cpu_held && plan[0].kind == K_PH1 && !plan[0].host && $urandom_range(3) == 0) begin
      cpu_rd = 1'b0; cpu_wt = 1'b0; cpu_held = 1'b0;
    end
    if (!cpu_held && slot >= 4'd7 && $urandom_range(7) == 0) begin
      r = int'($urandom_range(2));
      cpu_rd    = (r != 1);
      cpu_wt    = (r != 0);
      cpu_byte  = 1'($urandom);
      cpu_adr   = 16'($urandom);
      cpu_wdata = 16'($urandom);
      cpu_held  = 1'b1;
    end
    if (!host_held && $urandom_range(4) == 0) begin
      host_req   = 1'b1;
      host_we    = 1'($urandom);
      host_addr  = 18'($urandom);
      host_wdata = 16'($urandom);
      host_held  = 1'b1;
    end
  endtask

  task automatic run_cycle();
    @(posedge clk25);
    if (reset_n) model_edge();
    else model_reset();
    #1;
    slot = slot + 4'd1;
    if (cpu_held && exp_cpu_done) begin
      cpu_rd = 1'b0; cpu_wt = 1'b0; cpu_held = 1'b0;
    end
    if (host_held && exp_host_ack && (!rand_en || $urandom_range(3) != 0)) begin
      host_req = 1'b0; host_held = 1'b0;
    end
    if (rand_en) drive_random();
    @(negedge clk25);
    check_outputs();
    if (slot == 4'd0) frame++;
  endtask

  initial begin
    model_reset();
    repeat (3) run_cycle();
    check("rst_addr", ram_addr, 0);
    check("rst_oe_n", ram_oe_n, 1);
    check("rst_vid_data", vid_data, 0);
    check("rst_cpu_done", cpu_done, 0);

    // Release mid-frame with a CPU read already waiting: it must wait for a video fetch.
    cpu_rd = 1'b1; cpu_adr = 16'h0400; cpu_held = 1'b1;
    reset_n = 1'b1;

    while (frame < 6) begin
      run_cycle();
      if (frame == 0 && slot >= 4'd4) check("pre_vid_oe", ram_oe_n, 1);
      if (frame == 1) begin
        case (slot)
          4'd0: begin check("vid_addr", ram_addr, 18'h02123); check("vid_oe", ram_oe_n, 0); end
          4'd1: begin
            check("vid_valid_s1", vid_valid, 1); check("vid_a5a5", vid_data, 16'hA5A5);
            ram_dq_i = 16'h1234;
          end
          4'd4: begin check("rd_addr", ram_addr, 18'h00200); check("rd_oe_a", ram_oe_n, 0); end
          4'd5: check("rd_oe_b", ram_oe_n, 0);
          4'd6: begin
            check("rd_done", cpu_done, 1); check("rd_data", cpu_rdata, 16'h1234);
            cpu_wt = 1'b1; cpu_byte = 1'b1; cpu_adr = 16'h0201; cpu_wdata = 16'hBEEF;
            cpu_held = 1'b1;
          end
          default: ;
        endcase
      end
      if (frame == 2) begin
        case (slot)
          4'd3: check("wr_idle_s3", ram_dq_oe, 0);
          4'd4: begin
            check("wr_addr", ram_addr, 18'h00100); check("wr_lb_n", ram_lb_n, 1);
            check("wr_ub_n", ram_ub_n, 0); check("wr_we_a", ram_we_n, 0);
            check("wr_oe_a", ram_dq_oe, 1); check("wr_dq", ram_dq_o, 16'hBEEF);
          end
          4'd5: begin check("wr_we_b", ram_we_n, 1); check("wr_oe_b", ram_dq_oe, 1); end
          4'd6: begin check("wr_done", cpu_done, 1); check("wr_dq_off", ram_dq_oe, 0); end
          default: ;
        endcase
      end
      if (frame == 3) begin
        case (slot)
          4'd2: begin
            host_req = 1'b1; host_we = 1'b1; host_addr = 18'h08000; host_wdata = 16'h0042;
            host_held = 1'b1;
            cpu_rd = 1'b1; cpu_adr = 16'h0400; cpu_held = 1'b1;
          end
          4'd4: check("hc_cpu_addr", ram_addr, 18'h00200);
          4'd6: begin check("hc_cpu_done", cpu_done, 1); check("hc_idle6", ram_oe_n, 1); end
          4'd7: begin
            check("host_addr", ram_addr, 18'h08000); check("host_we_a", ram_we_n, 0);
            check("host_dq", ram_dq_o, 16'h0042); check("host_lanes", {ram_lb_n, ram_ub_n}, 0);
          end
          4'd8: begin check("host_we_b", ram_we_n, 1); check("host_oe_b", ram_dq_oe, 1); end
          4'd9: check("host_ack_s9", host_ack, 1);
          default: ;
        endcase
      end
      if (frame == 4) begin
        if (slot == 4'd1) begin
          cpu_wt = 1'b1; cpu_byte = 1'b0; cpu_adr = 16'h1234; cpu_wdata = 16'h5555;
          cpu_held = 1'b1;
        end
        if (slot == 4'd4) begin
          check("pre_rst_we", ram_we_n, 0);
          reset_n = 1'b0;
          #1;
          check("abort_we_n", ram_we_n, 1);
          check("abort_dq_oe", ram_dq_oe, 0);
          check("abort_addr", ram_addr, 0);
        end
        if (slot == 4'd6) begin
          check("abort_no_done", cpu_done, 0);
          reset_n = 1'b1;
        end
        if (slot >= 4'd7) begin
          check("post_rst_oe", ram_oe_n, 1);
          check("post_rst_we", ram_we_n, 1);
        end
      end
      if (frame == 5) begin
        if (slot == 4'd0) begin
          check("first_vid_oe", ram_oe_n, 0);
          check("first_vid_addr", ram_addr, {VB, vga_addr});
        end
        if (slot == 4'd6) check("retry_done", cpu_done, 1);
      end
    end

    rand_en = 1'b1;
    repeat (3000) run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
